// File: rtl/cache_params_pkg.sv
// Shared L1/L2 line geometry, drain state encoding and
// line address helper for the victim writeback path.
package cache_params_pkg;

  localparam int LINE_W  = 32;
  localparam int TAG_W   = 26;
  localparam int INDEX_W = 4;
  localparam int ADDR_W  = TAG_W + INDEX_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } drain_state_t;

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0]   tag,
    input logic [INDEX_W-1:0] index
  );
    return {tag, index, 2'b00};
  endfunction

endpackage

// File: rtl/wb_line_match.sv
// Tag+index lookup across buffer entries; picks the youngest
// matching entry (furthest from head) as a one-hot select.
module wb_line_match #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 26,
  parameter int INDEX_W = 4
) (
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0][TAG_W-1:0]   tags,
  input  logic [DEPTH-1:0][INDEX_W-1:0] idxs,
  input  logic [DEPTH-1:0]              mask,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [TAG_W-1:0]              q_tag,
  input  logic [INDEX_W-1:0]            q_index,
  output logic [DEPTH-1:0]              sel,
  output logic                          hit
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && !mask[i]
              && (tags[i] == q_tag)
              && (idxs[i] == q_index);
    end
  end

  // walk from head toward tail; the last match seen is youngest
  always_comb begin
    sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head + PTR_W'(k)]) begin
        sel = '0;
        sel[head + PTR_W'(k)] = 1'b1;
      end
    end
  end

  assign hit = |match;

endmodule

// File: rtl/l1_victim_wb_buffer.sv
// L1 victim writeback buffer: drops clean victims, queues and
// coalesces dirty lines, drains to L2, serves snoop lookups.
module l1_victim_wb_buffer #(
  parameter int DEPTH   = 4,
  parameter int LINE_W  = cache_params_pkg::LINE_W,
  parameter int TAG_W   = cache_params_pkg::TAG_W,
  parameter int INDEX_W = cache_params_pkg::INDEX_W,
  parameter int ADDR_W  = cache_params_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     evict_valid,
  output logic                     evict_ready,
  input  logic                     evict_dirty,
  input  logic [TAG_W-1:0]         evict_tag,
  input  logic [INDEX_W-1:0]       evict_index,
  input  logic [LINE_W-1:0]        evict_data,
  output logic                     wb_req,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [LINE_W-1:0]        wb_data,
  input  logic                     wb_ack,
  input  logic                     snoop_valid,
  input  logic [TAG_W-1:0]         snoop_tag,
  input  logic [INDEX_W-1:0]       snoop_index,
  output logic                     snoop_hit,
  output logic [LINE_W-1:0]        snoop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  import cache_params_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]              vld;
  logic [DEPTH-1:0][TAG_W-1:0]   tag_q;
  logic [DEPTH-1:0][INDEX_W-1:0] idx_q;
  logic [DEPTH-1:0][LINE_W-1:0]  data_q;
  logic [PTR_W-1:0]              head;
  logic [PTR_W-1:0]              tail;
  logic [CNT_W-1:0]              cnt;
  drain_state_t                  state;

  logic [DEPTH-1:0] head_mask;
  logic [DEPTH-1:0] co_sel;
  logic             co_hit;
  logic [DEPTH-1:0] sn_sel;
  logic             sn_hit;
  logic             push;
  logic             alloc;
  logic             merge;
  logic             pop;

  assign count       = cnt;
  assign empty       = (cnt == '0);
  assign full        = (cnt == CNT_W'(DEPTH));
  assign evict_ready = !full;

  assign push  = evict_valid && evict_dirty && evict_ready;
  assign alloc = push && !co_hit;
  assign merge = push && co_hit;
  assign pop   = (state == REQ) && wb_ack;

  // the in-flight head must not change under L2's feet
  assign head_mask = (state == REQ) ? (DEPTH'(1) << head) : '0;

  wb_line_match #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W)
  ) u_co_match (
    .valid   (vld),
    .tags    (tag_q),
    .idxs    (idx_q),
    .mask    (head_mask),
    .head    (head),
    .q_tag   (evict_tag),
    .q_index (evict_index),
    .sel     (co_sel),
    .hit     (co_hit)
  );

  wb_line_match #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W)
  ) u_sn_match (
    .valid   (vld),
    .tags    (tag_q),
    .idxs    (idx_q),
    .mask    ('0),
    .head    (head),
    .q_tag   (snoop_tag),
    .q_index (snoop_index),
    .sel     (sn_sel),
    .hit     (sn_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PTR_W'(1);
      end
      if (alloc) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PTR_W'(1);
      end
      case ({alloc, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[tail]  <= evict_tag;
      idx_q[tail]  <= evict_index;
      data_q[tail] <= evict_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (merge && co_sel[i]) begin
        data_q[i] <= evict_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wb_req <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state  <= REQ;
            wb_req <= 1'b1;
          end
        end
        REQ: begin
          if (wb_ack) begin
            state  <= GAP;
            wb_req <= 1'b0;
          end
        end
        GAP: begin
          state  <= IDLE;
          wb_req <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          wb_req <= 1'b0;
        end
      endcase
    end
  end

  assign wb_addr = vld[head] ? line_addr(tag_q[head], idx_q[head]) : '0;
  assign wb_data = vld[head] ? data_q[head] : '0;

  assign snoop_hit = snoop_valid && sn_hit;

  always_comb begin
    snoop_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (snoop_valid && sn_sel[i]) begin
        snoop_data = snoop_data | data_q[i];
      end
    end
  end

endmodule

// File: tb/tb_l1_victim_wb_buffer.sv
// Bench for l1_victim_wb_buffer: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_l1_victim_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        evict_valid;
  logic        evict_ready;
  logic        evict_dirty;
  logic [25:0] evict_tag;
  logic [3:0]  evict_index;
  logic [31:0] evict_data;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        snoop_valid;
  logic [25:0] snoop_tag;
  logic [3:0]  snoop_index;
  logic        snoop_hit;
  logic [31:0] snoop_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  l1_victim_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .evict_valid (evict_valid),
    .evict_ready (evict_ready),
    .evict_dirty (evict_dirty),
    .evict_tag   (evict_tag),
    .evict_index (evict_index),
    .evict_data  (evict_data),
    .wb_req      (wb_req),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_ack      (wb_ack),
    .snoop_valid (snoop_valid),
    .snoop_tag   (snoop_tag),
    .snoop_index (snoop_index),
    .snoop_hit   (snoop_hit),
    .snoop_data  (snoop_data),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [31:0] data;
  } line_t;

  // model: FIFO of pending lines, head in flight, post-pop lockout
  line_t mq[$];
  bit    m_busy;
  int    m_lock;
  bit    m_took;

  typedef struct {
    logic        ev;
    logic        dt;
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [31:0] data;
    logic        ack;
    logic        sv;
    logic [25:0] stag;
    logic [3:0]  sidx;
    logic [2:0]  e_cnt;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_hit;
    logic [31:0] e_sd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    int          sz;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        sh;
    logic [31:0] sd;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("evict_ready", 32'(evict_ready), 32'(sz < DEPTH));
    chk("wb_req", 32'(wb_req), 32'(m_busy));
    ea = '0;
    ed = '0;
    if (sz > 0) begin
      ea = {mq[0].tag, mq[0].idx, 2'b00};
      ed = mq[0].data;
    end
    chk("wb_addr", wb_addr, ea);
    chk("wb_data", wb_data, ed);
    sh = 1'b0;
    sd = '0;
    if (snoop_valid) begin
      for (int k = 0; k < sz; k++) begin
        if (mq[k].tag == snoop_tag && mq[k].idx == snoop_index) begin
          sh = 1'b1;
          sd = mq[k].data;
        end
      end
    end
    chk("snoop_hit", 32'(snoop_hit), 32'(sh));
    chk("snoop_data", snoop_data, sd);
  endtask

  task automatic model_edge();
    int    sz;
    int    j;
    bit    was_busy;
    bit    push;
    bit    pop;
    line_t ln;
    sz       = mq.size();
    was_busy = m_busy;
    push     = evict_valid && evict_dirty && (sz < DEPTH);
    pop      = m_busy && wb_ack;
    m_took   = evict_valid && (!evict_dirty || push);
    if (push) begin
      j = -1;
      for (int k = 0; k < sz; k++) begin
        if (mq[k].tag == evict_tag && mq[k].idx == evict_index
            && !(m_busy && k == 0)) j = k;
      end
      if (j >= 0) begin
        mq[j].data = evict_data;
      end else begin
        ln.tag  = evict_tag;
        ln.idx  = evict_index;
        ln.data = evict_data;
        mq.push_back(ln);
      end
    end
    if (pop) begin
      void'(mq.pop_front());
      m_busy = 1'b0;
      m_lock = 1;
    end else if (!was_busy) begin
      if (m_lock > 0) m_lock--;
      else if (sz > 0) m_busy = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    m_busy = 1'b0;
    m_lock = 0;
    m_took = 1'b1;
  endtask

  task automatic idle_inputs();
    evict_valid = 1'b0;
    evict_dirty = 1'b0;
    evict_tag   = '0;
    evict_index = '0;
    evict_data  = '0;
    wb_ack      = 1'b0;
    snoop_valid = 1'b0;
    snoop_tag   = '0;
    snoop_index = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic wait_req(string nm);
    int n;
    n = 0;
    while (wb_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 32'(wb_req), 32'd1);
  endtask

  task automatic push_line(logic [25:0] t, logic [3:0] i,
                           logic [31:0] d);
    int n;
    evict_valid = 1'b1;
    evict_dirty = 1'b1;
    evict_tag   = t;
    evict_index = i;
    evict_data  = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_took && n < 20);
    chk("push accepted", 32'(m_took), 32'd1);
    evict_valid = 1'b0;
    evict_dirty = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{'1, '1, 26'h155, 4'd3, 32'hDEADBEEF, '0,
                '0, 26'h155, 4'd3,
                3'd0, '0, 32'h0, 32'h0, '0, 32'h0};
    vecs[1] = '{'0, '0, 26'h0, 4'd0, 32'h0, '0,
                '1, 26'h155, 4'd3,
                3'd1, '0, 32'h554C, 32'hDEADBEEF,
                '1, 32'hDEADBEEF};
    vecs[2] = '{'0, '0, 26'h0, 4'd0, 32'h0, '1,
                '0, 26'h155, 4'd3,
                3'd1, '1, 32'h554C, 32'hDEADBEEF, '0, 32'h0};
    vecs[3] = '{'0, '0, 26'h0, 4'd0, 32'h0, '0,
                '1, 26'h155, 4'd3,
                3'd0, '0, 32'h0, 32'h0, '0, 32'h0};
    vecs[4] = '{'1, '0, 26'h7, 4'd1, 32'h12345678, '0,
                '1, 26'h7, 4'd1,
                3'd0, '0, 32'h0, 32'h0, '0, 32'h0};
    vecs[5] = '{'1, '0, 26'h7, 4'd1, 32'h12345678, '1,
                '1, 26'h7, 4'd1,
                3'd0, '0, 32'h0, 32'h0, '0, 32'h0};
    vecs[6] = '{'1, '0, 26'h9, 4'd2, 32'h55AA55AA, '0,
                '1, 26'h9, 4'd2,
                3'd0, '0, 32'h0, 32'h0, '0, 32'h0};
    vecs[7] = '{'0, '0, 26'h0, 4'd0, 32'h0, '0,
                '0, 26'h0, 4'd0,
                3'd0, '0, 32'h0, 32'h0, '0, 32'h0};

    // reset state
    do_reset();
    snoop_valid = 1'b1;
    #1;
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst ready", 32'(evict_ready), 32'd1);
    chk("rst wb_req", 32'(wb_req), 32'd0);
    chk("rst wb_addr", wb_addr, 32'h0);
    chk("rst wb_data", wb_data, 32'h0);
    chk("rst snoop_hit", 32'(snoop_hit), 32'd0);
    chk("rst snoop_data", snoop_data, 32'h0);
    chk("rst count", 32'(count), 32'd0);

    // single writeback and clean-only traffic
    do_reset();
    foreach (vecs[i]) begin
      evict_valid = vecs[i].ev;
      evict_dirty = vecs[i].dt;
      evict_tag   = vecs[i].tag;
      evict_index = vecs[i].idx;
      evict_data  = vecs[i].data;
      wb_ack      = vecs[i].ack;
      snoop_valid = vecs[i].sv;
      snoop_tag   = vecs[i].stag;
      snoop_index = vecs[i].sidx;
      @(negedge clk);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d wb_req", i), 32'(wb_req), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d wb_addr", i), wb_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_wd);
      chk($sformatf("vec%0d snoop_hit", i), 32'(snoop_hit), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d snoop_data", i), snoop_data, vecs[i].e_sd);
      @(posedge clk);
      model_edge();
      #1;
    end

    // fill, clean victims while full, held dirty victim
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_line(26'(32'h10 + i), 4'(i), 32'h100 + 32'(i));
    end
    chk("fill full", 32'(full), 32'd1);
    chk("fill ready", 32'(evict_ready), 32'd0);
    evict_valid = 1'b1;
    evict_dirty = 1'b0;
    evict_tag   = 26'h3F;
    evict_index = 4'd9;
    repeat (6) tick();
    chk("clean full count", 32'(count), 32'd4);
    evict_dirty = 1'b1;
    evict_tag   = 26'h20;
    evict_index = 4'd7;
    evict_data  = 32'h555;
    repeat (2) tick();
    chk("held count", 32'(count), 32'd4);
    chk("held wb_req", 32'(wb_req), 32'd1);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("pop count", 32'(count), 32'd3);
    chk("pop ready", 32'(evict_ready), 32'd1);
    tick();
    chk("held taken", 32'(m_took), 32'd1);
    chk("refill count", 32'(count), 32'd4);
    evict_valid = 1'b0;
    evict_dirty = 1'b0;
    wb_ack = 1'b1;
    for (int n = 0; n < 40 && !empty; n++) tick();
    wb_ack = 1'b0;
    chk("drain empty", 32'(empty), 32'd1);

    // coalesce behind an in-flight head
    do_reset();
    push_line(26'h3, 4'd1, 32'hAAAA);
    wait_req("coal req");
    push_line(26'hA, 4'd5, 32'h1111);
    push_line(26'hA, 4'd5, 32'h2222);
    chk("coal count", 32'(count), 32'd2);
    snoop_valid = 1'b1;
    snoop_tag   = 26'hA;
    snoop_index = 4'd5;
    #1;
    chk("coal snoop_hit", 32'(snoop_hit), 32'd1);
    chk("coal snoop_data", snoop_data, 32'h2222);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    wait_req("coal req2");
    chk("coal wb_addr", wb_addr, 32'h294);
    chk("coal wb_data", wb_data, 32'h2222);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;

    // same line re-evicted while it is the in-flight head
    do_reset();
    push_line(26'h77, 4'd2, 32'h1);
    wait_req("head req");
    push_line(26'h77, 4'd2, 32'h2);
    chk("head count", 32'(count), 32'd2);
    snoop_valid = 1'b1;
    snoop_tag   = 26'h77;
    snoop_index = 4'd2;
    #1;
    chk("head snoop_data", snoop_data, 32'h2);
    chk("head wb_data", wb_data, 32'h1);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    wait_req("head req2");
    chk("head wb_addr2", wb_addr, 32'h1DC8);
    chk("head wb_data2", wb_data, 32'h2);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("head empty", 32'(empty), 32'd1);

    // reset while a writeback is in flight
    do_reset();
    push_line(26'h1, 4'd1, 32'hA1);
    push_line(26'h2, 4'd2, 32'hA2);
    push_line(26'h3, 4'd3, 32'hA3);
    wait_req("mid req");
    chk("mid count", 32'(count), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    snoop_valid = 1'b1;
    snoop_tag   = 26'h1;
    snoop_index = 4'd1;
    #1;
    chk("mid rst wb_req", 32'(wb_req), 32'd0);
    chk("mid rst empty", 32'(empty), 32'd1);
    chk("mid rst snoop", 32'(snoop_hit), 32'd0);
    push_line(26'h4, 4'd4, 32'hB4);
    wait_req("after rst req");
    chk("after rst addr", wb_addr, 32'h110);
    chk("after rst data", wb_data, 32'hB4);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!(evict_valid && evict_dirty && !m_took)) begin
        evict_valid = ($urandom_range(0, 1) == 1);
        evict_dirty = ($urandom_range(0, 9) < 7);
        evict_tag   = 26'($urandom_range(0, 3));
        evict_index = 4'($urandom_range(0, 1));
        evict_data  = $urandom();
      end
      wb_ack      = ($urandom_range(0, 2) == 0);
      snoop_valid = ($urandom_range(0, 1) == 1);
      snoop_tag   = 26'($urandom_range(0, 3));
      snoop_index = 4'($urandom_range(0, 1));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
